// File: rtl/mul_frame_accumulator_pkg.sv
// mul_frame_accumulator_pkg: shared types and helpers for the frame accumulator
// Provides the FSM state enum, the counter-width helper and the saturating adder.
package mul_frame_accumulator_pkg;
   typedef enum logic {ACCUM, HOLD} acc_state_t;
   // Counter width for n products per frame, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
   // Returns {overflow, result}; result is clamped to 2^acc_w-1.
   function automatic logic [32:0] sat_add(input logic [31:0] acc, input logic [31:0] prod, input int unsigned acc_w);
      logic [32:0] sum, lim;
      sum = {1'b0, acc} + {1'b0, prod};
      lim = (33'd1 << acc_w) - 33'd1;
      return (sum > lim) ? {1'b1, lim[31:0]} : {1'b0, sum[31:0]};
   endfunction
endpackage

// File: rtl/mul_frame_accumulator_if.sv
// mul_frame_accumulator_if: product-in / frame-total-out handshake bundle
// master (producer/consumer side): drives in_valid, in_prod, out_ready, clear
// slave (accumulator side): drives in_ready, out_valid, out_sum, out_sat
interface mul_frame_accumulator_if #(
   parameter int PROD_W = 4,
   parameter int ACC_W  = 8
);
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_sat;
   modport master (output clear, in_valid, in_prod, out_ready, input in_ready, out_valid, out_sum, out_sat);
   modport slave  (input clear, in_valid, in_prod, out_ready, output in_ready, out_valid, out_sum, out_sat);
endinterface

// File: rtl/mul_frame_accumulator.sv
// mul_frame_accumulator: sums FRAME_LEN products into one saturated frame total
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of mul_frame_accumulator_if (clear, product in, total out)
module mul_frame_accumulator
   import mul_frame_accumulator_pkg::*;
#(
   parameter int PROD_W    = 4,
   parameter int ACC_W     = 8,
   parameter int FRAME_LEN = 8
) (
   input logic                      clk,
   input logic                      rst,
   mul_frame_accumulator_if.slave   bus
);
   localparam int CNT_W = cnt_width(FRAME_LEN);
   acc_state_t       state, state_n;
   logic [ACC_W-1:0] acc, res;
   logic [CNT_W-1:0] cnt;
   logic [32:0]      add;
   logic             sat, ovf, accept, last;
   assign add    = sat_add(32'(acc), 32'(bus.in_prod), ACC_W);
   assign res    = add[ACC_W-1:0];
   // Bits above ACC_W are zero once clamped; folding them in keeps the flag defensive.
   assign ovf    = add[32] | (|(add[31:0] >> ACC_W));
   assign accept = bus.in_valid && bus.in_ready;
   assign last   = cnt == CNT_W'(FRAME_LEN - 1);
   always_ff @(posedge clk) begin
      if (rst || bus.clear) state <= ACCUM;
      else state <= state_n;
   end
   always_comb begin
      state_n = (state == ACCUM) ? ((accept && last) ? HOLD : ACCUM) : (bus.out_ready ? ACCUM : HOLD);
   end
   always_comb begin
      bus.in_ready = state == ACCUM;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc           <= '0;
         cnt           <= '0;
         sat           <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_sum   <= '0;
         bus.out_sat   <= 1'b0;
      end else if (bus.clear) begin
         acc           <= '0;
         cnt           <= '0;
         sat           <= 1'b0;
         bus.out_valid <= 1'b0;
      end else if (accept && last) begin
         acc           <= '0;
         cnt           <= '0;
         sat           <= 1'b0;
         bus.out_valid <= 1'b1;
         bus.out_sum   <= res;
         bus.out_sat   <= sat | ovf;
      end else if (accept) begin
         acc <= res;
         cnt <= cnt + 1'b1;
         sat <= sat | ovf;
      end else if (state == HOLD && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mul_frame_accumulator.sv
// tb_mul_frame_accumulator: directed and randomized checks of the frame accumulator
module tb_mul_frame_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   mul_frame_accumulator_if #(.PROD_W(4), .ACC_W(8)) m8 ();
   mul_frame_accumulator_if #(.PROD_W(4), .ACC_W(6)) m6 ();
   mul_frame_accumulator_if #(.PROD_W(4), .ACC_W(8)) m1 ();
   mul_frame_accumulator #(.PROD_W(4), .ACC_W(8), .FRAME_LEN(8)) u8 (.clk(clk), .rst(rst), .bus(m8.slave));
   mul_frame_accumulator #(.PROD_W(4), .ACC_W(6), .FRAME_LEN(8)) u6 (.clk(clk), .rst(rst), .bus(m6.slave));
   mul_frame_accumulator #(.PROD_W(4), .ACC_W(8), .FRAME_LEN(1)) u1 (.clk(clk), .rst(rst), .bus(m1.slave));
   // Golden 2x2 multiplier feeding the accumulator.
   function automatic logic [3:0] lut_mul(input logic [1:0] a, input logic [1:0] b);
      return {2'b00, a} * {2'b00, b};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   initial begin
      int p3[8] = '{1, 2, 3, 4, 6, 9, 0, 2};
      int q[$];
      int acc_n, fcnt, fsum, cyc, exp_v;
      bit holding;
      logic [1:0] a, b;
      m8.clear = 0; m8.in_valid = 0; m8.in_prod = 0; m8.out_ready = 0;
      m6.clear = 0; m6.in_valid = 0; m6.in_prod = 0; m6.out_ready = 0;
      m1.clear = 0; m1.in_valid = 0; m1.in_prod = 0; m1.out_ready = 0;
      // reset
      repeat (3) step();
      rst = 0;
      step();
      chk("rst_out_valid", m8.out_valid, 0);
      chk("rst_out_sum", m8.out_sum, 0);
      chk("rst_out_sat", m8.out_sat, 0);
      chk("rst_in_ready", m8.in_ready, 1);
      // 8 x (3*3)
      m8.in_valid = 1; m8.in_prod = lut_mul(2'd3, 2'd3); m8.out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         chk("b2b_in_ready", m8.in_ready, 1);
         step();
      end
      m8.in_valid = 0;
      chk("b2b_out_valid", m8.out_valid, 1);
      chk("b2b_out_sum", m8.out_sum, 72);
      chk("b2b_out_sat", m8.out_sat, 0);
      chk("b2b_hold_in_ready", m8.in_ready, 0);
      step();
      chk("b2b_done_valid", m8.out_valid, 0);
      chk("b2b_ready_back", m8.in_ready, 1);
      chk("b2b_sum_kept", m8.out_sum, 72);
      // back-pressure with in_valid held high
      m8.out_ready = 0; m8.in_valid = 1;
      for (int i = 0; i < 8; i++) begin
         m8.in_prod = 4'(p3[i]);
         step();
      end
      m8.in_prod = 7;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", m8.out_valid, 1);
         chk("bp_out_sum", m8.out_sum, 27);
         chk("bp_in_ready", m8.in_ready, 0);
         step();
      end
      m8.out_ready = 1;
      step();
      chk("bp_release_valid", m8.out_valid, 0);
      m8.in_prod = 7;
      step();
      m8.in_prod = 1;
      repeat (7) step();
      m8.in_valid = 0;
      chk("bp_next_frame_sum", m8.out_sum, 14);
      chk("bp_next_frame_valid", m8.out_valid, 1);
      step();
      // ACC_W=6 saturation, then sat clears per frame
      m6.in_valid = 1; m6.in_prod = 9; m6.out_ready = 1;
      repeat (8) step();
      m6.in_valid = 0;
      chk("sat_valid", m6.out_valid, 1);
      chk("sat_sum", m6.out_sum, 63);
      chk("sat_flag", m6.out_sat, 1);
      step();
      m6.in_valid = 1; m6.in_prod = 1;
      repeat (8) step();
      m6.in_valid = 0;
      chk("sat2_sum", m6.out_sum, 8);
      chk("sat2_flag", m6.out_sat, 0);
      step();
      // clear mid-frame, then clear in HOLD
      m8.out_ready = 0; m8.in_valid = 1; m8.in_prod = 4;
      repeat (3) step();
      m8.clear = 1; m8.in_prod = 5;
      step();
      m8.clear = 0;
      chk("clr_valid", m8.out_valid, 0);
      chk("clr_in_ready", m8.in_ready, 1);
      m8.in_prod = 2;
      for (int i = 0; i < 8; i++) begin
         chk("clr_no_early_result", m8.out_valid, 0);
         step();
      end
      m8.in_valid = 0;
      chk("clr_frame_valid", m8.out_valid, 1);
      chk("clr_frame_sum", m8.out_sum, 16);
      chk("clr_frame_sat", m8.out_sat, 0);
      m8.clear = 1;
      step();
      m8.clear = 0;
      chk("clr_hold_valid", m8.out_valid, 0);
      chk("clr_hold_in_ready", m8.in_ready, 1);
      // FRAME_LEN=1
      m1.out_ready = 1; m1.in_valid = 1; m1.in_prod = lut_mul(2'd1, 2'd2);
      step();
      m1.in_prod = lut_mul(2'd3, 2'd3);
      chk("f1_valid", m1.out_valid, 1);
      chk("f1_sum_a", m1.out_sum, 2);
      step();
      chk("f1_ready_back", m1.in_ready, 1);
      step();
      m1.in_valid = 0;
      chk("f1_sum_b", m1.out_sum, 9);
      step();
      // randomized frames against a scoreboard of frame totals
      acc_n = 0; fcnt = 0; fsum = 0; cyc = 0; holding = 0;
      while (acc_n < 1000 && cyc < 20000) begin
         a = 2'($urandom_range(3)); b = 2'($urandom_range(3));
         m8.in_prod = lut_mul(a, b);
         m8.in_valid = $urandom_range(3) != 0;
         m8.out_ready = $urandom_range(2) != 0;
         chk("rnd_in_ready", m8.in_ready, 32'(!holding));
         chk("rnd_out_valid", m8.out_valid, 32'(holding));
         if (holding && m8.out_ready) begin
            exp_v = q.pop_front();
            chk("rnd_sum", m8.out_sum, exp_v);
            chk("rnd_sat", m8.out_sat, 0);
            holding = 0;
         end else if (!holding && m8.in_valid) begin
            fsum += int'(m8.in_prod);
            fcnt++;
            acc_n++;
            if (fcnt == 8) begin
               q.push_back(fsum > 255 ? 255 : fsum);
               holding = 1; fcnt = 0; fsum = 0;
            end
         end
         step();
         cyc++;
      end
      chk("rnd_accepts", acc_n, 1000);
      m8.in_valid = 0; m8.out_ready = 1;
      if (holding) begin
         chk("rnd_drain_valid", m8.out_valid, 1);
         exp_v = q.pop_front();
         chk("rnd_drain_sum", m8.out_sum, exp_v);
         step();
      end
      chk("rnd_queue_empty", q.size(), 0);
      // reset while holding a result
      m8.out_ready = 0; m8.in_valid = 1; m8.in_prod = 9;
      repeat (8) step();
      m8.in_valid = 0;
      chk("rsth_valid_before", m8.out_valid, 1);
      rst = 1;
      step();
      rst = 0;
      chk("rsth_valid", m8.out_valid, 0);
      chk("rsth_sum", m8.out_sum, 0);
      chk("rsth_sat", m8.out_sat, 0);
      chk("rsth_in_ready", m8.in_ready, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
